// File: rtl/wb_scheduler.sv
// wb_scheduler: merges write-back requests from five execution units
// (alu, fpu, imm, jump, mov) into one registered conveyor beat per cycle.
// Units whose stamp/take register masks do not overlap are merged into the
// same beat. A round-robin pointer chooses which unit is visited first.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   unit_valid[4:0]     per-unit request (0..4 = alu, fpu, imm, jump, mov)
//   unit_ready[4:0]     per-unit grant (combinational)
//   unit_stamp_flat     5 x 24-bit stamp vectors, 3 bits per register
//   unit_stamp_in       5 x 8-bit stamp masks
//   unit_take_flat      5 x 40-bit take vectors, 5 bits per register
//   unit_take_in        5 x 8-bit take masks
//   conveyor_valid      registered beat valid
//   conveyor_ready      downstream accepts the beat
//   conveyor_*          registered merged beat, same packing as unit side
//   conflict_cnt        saturating count of load cycles with a denied requester
module wb_scheduler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         unit_valid,
  output logic [4:0]         unit_ready,
  input  logic [119:0]       unit_stamp_flat,
  input  logic [39:0]        unit_stamp_in,
  input  logic [199:0]       unit_take_flat,
  input  logic [39:0]        unit_take_in,
  output logic               conveyor_valid,
  input  logic               conveyor_ready,
  output logic [23:0]        conveyor_stamp_flat,
  output logic [7:0]         conveyor_stamp_in,
  output logic [39:0]        conveyor_take_flat,
  output logic [7:0]         conveyor_take_in,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam int unsigned N_UNITS = 5;
  localparam int unsigned N_REGS  = 8;
  localparam int unsigned MASK_W  = 8;
  localparam int unsigned STAMP_W = 3;
  localparam int unsigned TAKE_W  = 5;
  localparam int unsigned SF_W    = N_REGS * STAMP_W;
  localparam int unsigned TF_W    = N_REGS * TAKE_W;

  // Output register and scheduler state
  logic              valid_q;
  logic [SF_W-1:0]   stamp_flat_q, stamp_flat_d;
  logic [MASK_W-1:0] stamp_in_q, stamp_in_d;
  logic [TF_W-1:0]   take_flat_q, take_flat_d;
  logic [MASK_W-1:0] take_in_q, take_in_d;
  logic [2:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              load;
  logic [4:0]        grant;
  logic [2:0]        first_idx;
  logic [2:0]        vis_idx;
  logic              found;
  logic [MASK_W-1:0] used_s, used_t;
  logic              denied;

  // Unit visited at offset k from the round-robin base, modulo 5
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned k);
    logic [3:0] sum;
    sum = 4'(base) + 4'(k);
    return (sum >= 4'(N_UNITS)) ? 3'(sum - 4'(N_UNITS)) : 3'(sum);
  endfunction

  assign load = !valid_q || conveyor_ready;

  // Round-robin grant: merge each valid unit whose masks are disjoint from
  // everything granted so far. The first valid unit always sees empty
  // unions and is therefore always granted.
  always_comb begin
    grant     = '0;
    used_s    = '0;
    used_t    = '0;
    first_idx = '0;
    vis_idx   = '0;
    found     = 1'b0;
    if (load && reset) begin
      for (int unsigned k = 0; k < N_UNITS; k++) begin
        vis_idx = rr_idx(rr_q, k);
        if (unit_valid[vis_idx]
            && ((unit_stamp_in[32'(vis_idx)*MASK_W +: MASK_W] & used_s) == '0)
            && ((unit_take_in[32'(vis_idx)*MASK_W +: MASK_W] & used_t) == '0)) begin
          grant[vis_idx] = 1'b1;
          used_s = used_s | unit_stamp_in[32'(vis_idx)*MASK_W +: MASK_W];
          used_t = used_t | unit_take_in[32'(vis_idx)*MASK_W +: MASK_W];
          if (!found) begin
            first_idx = vis_idx;
            found     = 1'b1;
          end
        end
      end
    end
  end

  assign unit_ready = grant;
  assign denied     = |(unit_valid & ~grant);

  // Merged payload: granted masks are disjoint, so OR-ing each slot's
  // owner field yields exactly that owner's value; unowned slots stay 0.
  always_comb begin
    stamp_in_d   = '0;
    take_in_d    = '0;
    stamp_flat_d = '0;
    take_flat_d  = '0;
    for (int unsigned u = 0; u < N_UNITS; u++) begin
      if (grant[u]) begin
        stamp_in_d = stamp_in_d | unit_stamp_in[u*MASK_W +: MASK_W];
        take_in_d  = take_in_d  | unit_take_in[u*MASK_W +: MASK_W];
        for (int unsigned r = 0; r < N_REGS; r++) begin
          if (unit_stamp_in[u*MASK_W + r]) begin
            stamp_flat_d[r*STAMP_W +: STAMP_W] = stamp_flat_d[r*STAMP_W +: STAMP_W]
              | unit_stamp_flat[u*SF_W + r*STAMP_W +: STAMP_W];
          end
          if (unit_take_in[u*MASK_W + r]) begin
            take_flat_d[r*TAKE_W +: TAKE_W] = take_flat_d[r*TAKE_W +: TAKE_W]
              | unit_take_flat[u*TF_W + r*TAKE_W +: TAKE_W];
          end
        end
      end
    end
  end

  // Pointer moves past the first granted unit; counter saturates
  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (|grant) begin
      rr_d = (first_idx == 3'd4) ? 3'd0 : first_idx + 3'd1;
    end
    if (load && denied && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output register, pointer and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      stamp_flat_q <= '0;
      stamp_in_q   <= '0;
      take_flat_q  <= '0;
      take_in_q    <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      if (load) begin
        valid_q      <= |grant;
        stamp_flat_q <= stamp_flat_d;
        stamp_in_q   <= stamp_in_d;
        take_flat_q  <= take_flat_d;
        take_in_q    <= take_in_d;
      end
    end
  end

  assign conveyor_valid      = valid_q;
  assign conveyor_stamp_flat = stamp_flat_q;
  assign conveyor_stamp_in   = stamp_in_q;
  assign conveyor_take_flat  = take_flat_q;
  assign conveyor_take_in    = take_in_q;
  assign conflict_cnt        = cnt_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: a behavioural model predicts grants and
// merged beats; expected beats are queued at grant time and compared when the
// conveyor handshake completes. A second instance with CNT_W = 2 checks
// counter saturation under the same stimulus.
module tb_wb_scheduler;

  typedef struct packed {
    logic [7:0]  si;
    logic [7:0]  ti;
    logic [23:0] sf;
    logic [39:0] tf;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  v;
  logic [7:0]  sin [5];
  logic [7:0]  tin [5];
  logic [23:0] sf  [5];
  logic [39:0] tf  [5];
  logic        cr;

  logic [119:0] usf;
  logic [39:0]  usi;
  logic [199:0] utf;
  logic [39:0]  uti;

  for (genvar g = 0; g < 5; g++) begin : g_pack
    assign usf[24*g +: 24] = sf[g];
    assign usi[8*g +: 8]   = sin[g];
    assign utf[40*g +: 40] = tf[g];
    assign uti[8*g +: 8]   = tin[g];
  end

  logic [4:0]  ur, ur_s;
  logic        cv, cv_s;
  logic [23:0] csf, csf_s;
  logic [7:0]  csi, csi_s, cti, cti_s;
  logic [39:0] ctf, ctf_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  wb_scheduler #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .unit_valid(v), .unit_ready(ur),
    .unit_stamp_flat(usf), .unit_stamp_in(usi), .unit_take_flat(utf), .unit_take_in(uti),
    .conveyor_valid(cv), .conveyor_ready(cr), .conveyor_stamp_flat(csf),
    .conveyor_stamp_in(csi), .conveyor_take_flat(ctf), .conveyor_take_in(cti),
    .conflict_cnt(cnt)
  );

  wb_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .unit_valid(v), .unit_ready(ur_s),
    .unit_stamp_flat(usf), .unit_stamp_in(usi), .unit_take_flat(utf), .unit_take_in(uti),
    .conveyor_valid(cv_s), .conveyor_ready(cr), .conveyor_stamp_flat(csf_s),
    .conveyor_stamp_in(csi_s), .conveyor_take_flat(ctf_s), .conveyor_take_in(cti_s),
    .conflict_cnt(cnt_s)
  );

  // Model state
  int          m_rr;
  logic        m_cv;
  beat_t       m_beat;
  int          m_cnt, m_cnt_s;
  beat_t       sb [$];
  logic [4:0]  ur_pre;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] mdl_grant();
    logic [4:0] g  = '0;
    logic [7:0] us = '0;
    logic [7:0] ut = '0;
    int u;
    if (!reset || (m_cv && !cr)) return '0;
    for (int k = 0; k < 5; k++) begin
      u = (m_rr + k) % 5;
      if (v[u] && ((sin[u] & us) == 8'h00) && ((tin[u] & ut) == 8'h00)) begin
        g[u] = 1'b1;
        us = us | sin[u];
        ut = ut | tin[u];
      end
    end
    return g;
  endfunction

  // Expected beat: find the owning unit of each register slot
  function automatic beat_t mdl_beat(input logic [4:0] g);
    beat_t b = '0;
    for (int u = 0; u < 5; u++) begin
      if (g[u]) begin
        b.si = b.si | sin[u];
        b.ti = b.ti | tin[u];
      end
    end
    for (int r = 0; r < 8; r++) begin
      for (int u = 0; u < 5; u++) begin
        if (g[u] && sin[u][r]) b.sf[3*r +: 3] = sf[u][3*r +: 3];
        if (g[u] && tin[u][r]) b.tf[5*r +: 5] = tf[u][5*r +: 5];
      end
    end
    return b;
  endfunction

  task automatic mdl_reset();
    m_rr = 0; m_cv = 1'b0; m_beat = '0; m_cnt = 0; m_cnt_s = 0;
    sb.delete();
  endtask

  task automatic clear_inputs();
    v = '0;
    for (int u = 0; u < 5; u++) begin
      sin[u] = '0; tin[u] = '0; sf[u] = '0; tf[u] = '0;
    end
  endtask

  // One clock: called just after a falling edge with inputs already driven
  task automatic step();
    logic [4:0] g;
    logic       ld;
    beat_t      b, nb;
    int         first;
    #2;
    g  = mdl_grant();
    ld = !m_cv || cr;
    ur_pre = ur;
    check("unit_ready", 64'(ur), 64'(g));
    if (cv && cr) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", 64'(1), 64'(0));
      end else begin
        b = sb.pop_front();
        check("beat_stamp_in", 64'(csi), 64'(b.si));
        check("beat_take_in", 64'(cti), 64'(b.ti));
        check("beat_stamp_flat", 64'(csf), 64'(b.sf));
        check("beat_take_flat", 64'(ctf), 64'(b.tf));
      end
    end
    nb = mdl_beat(g);
    if (g != '0) sb.push_back(nb);
    @(posedge clk);
    if (ld) begin
      m_cv   = |g;
      m_beat = nb;
      if ((v & ~g) != '0) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
      first = -1;
      for (int k = 0; k < 5; k++) begin
        if (first < 0 && g[(m_rr + k) % 5]) first = (m_rr + k) % 5;
      end
      if (first >= 0) m_rr = (first + 1) % 5;
    end
    #1;
    check("conveyor_valid", 64'(cv), 64'(m_cv));
    check("conveyor_stamp_in", 64'(csi), 64'(m_beat.si));
    check("conveyor_take_flat", 64'(ctf), 64'(m_beat.tf));
    check("conflict_cnt", 64'(cnt), 64'(m_cnt));
    check("conflict_cnt_sat", 64'(cnt_s), 64'(m_cnt_s));
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    cr = 1'b1;
    clear_inputs();
    mdl_reset();
    ur_pre = '0;
    reset = 1'b0;
    @(negedge clk);
    v = 5'b11111;
    #1;
    check("rst_valid", 64'(cv), 64'(0));
    check("rst_cnt", 64'(cnt), 64'(0));
    check("rst_ready", 64'(ur), 64'(0));
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Non-conflicting merge of alu stamp and fpu take
    v      = 5'b00011;
    sin[0] = 8'h01; sf[0] = 24'hABCDE3;
    tin[1] = 8'h02; tf[1] = 40'hAA_AAAA_AAAA; tf[1][9:5] = 5'd7;
    step();
    check("merge_ready", 64'(ur_pre), 64'(5'b00011));
    check("merge_stamp_in", 64'(csi), 64'(8'h01));
    check("merge_take_in", 64'(cti), 64'(8'h02));
    check("merge_stamp_flat", 64'(csf), 64'(24'h000003));
    check("merge_take_flat", 64'(ctf), 64'(40'h00_0000_00E0));
    check("merge_cnt", 64'(cnt), 64'(0));
    clear_inputs();
    step();

    // Conflict round-robin: everyone wants stamp reg 2
    reset_pulse();
    v = 5'b11111;
    for (int u = 0; u < 5; u++) begin
      sin[u] = 8'h04; sf[u] = 24'($urandom);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_order", 64'(ur_pre), 64'(5'b00001 << i));
      v[i] = 1'b0;
    end
    check("rr_cnt", 64'(cnt), 64'(4));
    check("rr_cnt_sat", 64'(cnt_s), 64'(3));

    // Continuous conflict keeps the narrow counter pinned at all-ones
    v = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_hold", 64'(cnt_s), 64'(3));
    end

    // Backpressure with a beat pending
    cr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 64'(ur_pre), 64'(0));
      check("bp_cnt", 64'(cnt), 64'(7));
    end
    cr = 1'b1;
    step();
    check("bp_release_grant", 64'(|ur_pre), 64'(1));

    // Zero-mask request from jump
    clear_inputs();
    step();
    v = 5'b01000;
    step();
    check("zero_ready", 64'(ur_pre), 64'(5'b01000));
    check("zero_valid", 64'(cv), 64'(1));
    check("zero_stamp_in", 64'(csi), 64'(0));
    check("zero_take_in", 64'(cti), 64'(0));

    // Random traffic; unserved requesters hold their payload
    clear_inputs();
    ur_pre = '0;
    for (int i = 0; i < 300; i++) begin
      cr = ($urandom_range(0, 3) != 0);
      for (int u = 0; u < 5; u++) begin
        if (!(v[u] && !ur_pre[u])) begin
          v[u]   = ($urandom_range(0, 2) != 0);
          sin[u] = 8'($urandom) & 8'($urandom) & 8'($urandom);
          tin[u] = 8'($urandom) & 8'($urandom) & 8'($urandom);
          sf[u]  = 24'($urandom);
          tf[u]  = {8'($urandom), 32'($urandom)};
        end
      end
      step();
    end

    // Asynchronous reset while a beat is pending
    cr = 1'b1;
    v = 5'b00100; sin[2] = 8'h10; tin[2] = 8'h01;
    step();
    v = 5'b11111;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(cv), 64'(0));
    check("arst_cnt", 64'(cnt), 64'(0));
    check("arst_stamp_in", 64'(csi), 64'(0));
    check("arst_ready", 64'(ur), 64'(0));
    mdl_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int u = 0; u < 5; u++) begin
      sin[u] = 8'h04; tin[u] = 8'h00;
    end
    step();
    check("arst_rr_restart", 64'(ur_pre), 64'(5'b00001));

    // Drain and confirm every granted beat was delivered
    clear_inputs();
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the conflict-stall counter.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port unit_valid, input, 5: per-unit write-back request; bit index 0..4 = alu, fpu, imm, jump, mov.
REQ-005 SHALL have port unit_ready, output, 5: per-unit grant; handshake completes when valid and ready are both 1.
REQ-006 SHALL have port unit_stamp_flat, input, 120: unit u's 24-bit stamp vector at [24u+23:24u]; register r's 3-bit stamp at [3r+2:3r] within it.
REQ-007 SHALL have port unit_stamp_in, input, 40: unit u's 8-bit stamp mask at [8u+7:8u].
REQ-008 SHALL have port unit_take_flat, input, 200: unit u's 40-bit take vector at [40u+39:40u]; register r's 5-bit take at [5r+4:5r] within it.
REQ-009 SHALL have port unit_take_in, input, 40: unit u's 8-bit take mask at [8u+7:8u].
REQ-010 SHALL have port conveyor_valid, output, 1: registered beat valid.
REQ-011 SHALL have port conveyor_ready, input, 1: conveyor accepts the beat.
REQ-012 SHALL have ports conveyor_stamp_flat (output, 24), conveyor_stamp_in (output, 8), conveyor_take_flat (output, 40) and conveyor_take_in (output, 8), all registered and using the same packing as REQ-006 to REQ-009.
REQ-013 SHALL have port conflict_cnt, output, CNT_W: saturating count of cycles in which a requester was denied because of a conflict.

Function
REQ-014 SHALL hold a one-entry output register (conveyor_* outputs) plus a 3-bit round-robin pointer rr_ptr in range 0..4.
REQ-015 SHALL define "load" = !conveyor_valid || conveyor_ready.
REQ-016 SHALL drive unit_ready to 0 for every unit when load = 0.
REQ-017 SHALL, when load = 1, visit units in order rr_ptr, rr_ptr+1, ... mod 5.
REQ-018 SHALL grant a visited unit only if it is valid and its stamp_in and take_in masks do not overlap the union of the masks already granted this cycle.
REQ-019 SHALL grant the first valid unit visited unconditionally, which guarantees progress.
REQ-020 SHALL compute unit_ready combinationally as the grant vector, with no dependence on unit_ready itself.
REQ-021 SHALL, on a load cycle, set the next conveyor_stamp_in / conveyor_take_in to the OR of the granted masks, and set each active slot's field to the value from the unit that owns that bit.
REQ-022 SHALL set each inactive slot's field to 0.
REQ-023 SHALL set the next conveyor_valid = |grant.
REQ-024 SHALL produce a beat with all-zero masks (conveyor_valid = 1) when a valid unit with all-zero masks is granted.
REQ-025 SHALL hold the output register unchanged when load = 0.
REQ-026 SHALL have latency of 1: a grant in cycle N makes conveyor_valid = 1 in cycle N+1.
REQ-027 SHALL sustain throughput of one beat per cycle while conveyor_ready = 1.
REQ-028 SHALL, when any grant occurs, set rr_ptr to (index of first granted unit + 1) mod 5 on the next edge; otherwise rr_ptr is held.
REQ-029 SHALL increment conflict_cnt by 1 on each load cycle in which at least one valid unit is denied.
REQ-030 SHALL saturate conflict_cnt at all-ones, with no wrap-around.
REQ-031 SHALL not count cycles with load = 0 (backpressure stalls) in conflict_cnt.
REQ-032 SHALL treat a requester that drops valid before ready as not granted; requesters SHALL hold their payload stable while valid && !ready.
REQ-033 SHALL ignore masks of units with unit_valid = 0.

Reset
REQ-034 SHALL, while reset = 0, asynchronously clear conveyor_valid, all conveyor_* fields, rr_ptr and conflict_cnt to 0.
REQ-035 SHALL hold unit_ready at 0 while reset = 0.
REQ-036 SHALL discard any pending output beat on reset asserted mid-operation; the first possible grant is on the first rising edge after reset deasserts.

Verification
REQ-037 SHALL cover non-conflicting merge: alu stamp_in = 0x01 (stamp 3), fpu take_in = 0x02 (take 7), both valid, conveyor_ready = 1 -> unit_ready = 5'b00011; next cycle conveyor_stamp_in = 0x01, conveyor_take_in = 0x02, stamp slot 0 = 3, take slot 1 = 7, conflict_cnt = 0.
REQ-038 SHALL cover conflict round-robin: all 5 units valid with stamp_in = 0x04 for 5 cycles -> grants alu, fpu, imm, jump, mov in that order, one per cycle; conflict_cnt = 4.
REQ-039 SHALL cover backpressure: beat pending with conveyor_ready = 0 for 3 cycles -> unit_ready = 0 and outputs stable; conflict_cnt unchanged; on the cycle ready = 1 a new grant occurs.
REQ-040 SHALL cover saturation: CNT_W = 2 with continuous conflict -> conflict_cnt reaches 3 and holds at 3.
REQ-041 SHALL cover reset mid-beat: reset = 0 asynchronously while conveyor_valid = 1 -> conveyor_valid = 0 and rr_ptr = 0 immediately, without waiting for a clock edge.
REQ-042 SHALL cover the zero-mask request: jump valid with both masks 0 -> granted; next cycle conveyor_valid = 1 with masks 0x00.
